// File: rtl/hall_pattern_gen.sv
// hall_pattern_gen
// Emulated hall-sensor source. It steps through the six-state hall code
// sequence at a programmable rate so the commutation path can run without
// a motor attached. It also reports a reference 120-electrical-degree time
// for cross-checking the measured one.
module hall_pattern_gen #(
  parameter int unsigned PRESC_DIV  = 100,
  parameter int unsigned MIN_PERIOD = 4,
  parameter logic [2:0]  FAULT_CODE = 3'b000
) (
  input  logic        controlCLK,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        dir,
  input  logic [15:0] period_in,
  input  logic        period_wr,
  input  logic        fault_inject,
  output logic [2:0]  HS,
  output logic        step_pulse,
  output logic [2:0]  pos_index,
  output logic [15:0] ele120_ref,
  output logic        ele120_valid,
  output logic        running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(PRESC_DIV - 1);
  localparam logic [15:0] MIN_P      = 16'(MIN_PERIOD);

  state_t      state;
  logic [15:0] shadow_period;
  logic [15:0] active_period;
  logic [15:0] presc_cnt;
  logic [15:0] step_cnt;
  logic [15:0] last_dur;
  logic        first_done;
  logic        fault_pending;

  logic [15:0] period_clamped;
  logic [15:0] shadow_next;
  logic [16:0] dur_sum;
  logic [15:0] dur_sat;
  logic        tick;
  logic        boundary;
  logic [2:0]  idx_next;

  // Hall code for each sequence index; out-of-range indices fall back to index 0.
  function automatic logic [2:0] hall_code(input logic [2:0] idx);
    case (idx)
      3'd0:    hall_code = 3'b001;
      3'd1:    hall_code = 3'b011;
      3'd2:    hall_code = 3'b010;
      3'd3:    hall_code = 3'b110;
      3'd4:    hall_code = 3'b100;
      3'd5:    hall_code = 3'b101;
      default: hall_code = 3'b001;
    endcase
  endfunction

  // Next sequence index, wrapping modulo 6 in either direction.
  function automatic logic [2:0] step_index(input logic [2:0] idx, input logic fwd);
    if (fwd) begin
      step_index = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      step_index = (idx == 3'd0 || idx > 3'd5) ? 3'd5 : idx - 3'd1;
    end
  endfunction

  // Step timing decode: period clamp, write-through shadow value, tick, boundary and duration sum.
  always_comb begin
    period_clamped = (period_in < MIN_P) ? MIN_P : period_in;
    shadow_next    = period_wr ? period_clamped : shadow_period;
    tick           = (state == RUN) && (presc_cnt == PRESC_LAST);
    boundary       = tick && (step_cnt == active_period - 16'd1);
    idx_next       = step_index(pos_index, dir);
    dur_sum        = {1'b0, last_dur} + {1'b0, active_period};
    dur_sat        = dur_sum[16] ? 16'hFFFF : dur_sum[15:0];
  end

  // Shadow period register, loaded by the host strobe with the clamped value.
  always_ff @(posedge controlCLK or negedge rst_n) begin
    if (!rst_n) begin
      shadow_period <= MIN_P;
    end else if (period_wr) begin
      shadow_period <= period_clamped;
    end
  end

  // Main sequencer: IDLE/RUN control, prescaler, step counter, hall output and ele120 history.
  always_ff @(posedge controlCLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      HS            <= 3'b001;
      pos_index     <= 3'd0;
      step_pulse    <= 1'b0;
      ele120_ref    <= 16'd0;
      ele120_valid  <= 1'b0;
      running       <= 1'b0;
      presc_cnt     <= 16'd0;
      step_cnt      <= 16'd0;
      active_period <= MIN_P;
      last_dur      <= 16'd0;
      first_done    <= 1'b0;
      fault_pending <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          running   <= 1'b0;
          presc_cnt <= 16'd0;
          step_cnt  <= 16'd0;
          if (enable) begin
            state         <= RUN;
            running       <= 1'b1;
            active_period <= shadow_next;
            ele120_valid  <= 1'b0;
            ele120_ref    <= 16'd0;
            last_dur      <= 16'd0;
            first_done    <= 1'b0;
          end
        end
        RUN: begin
          if (fault_inject) begin
            fault_pending <= 1'b1;
          end
          if (!enable) begin
            state     <= IDLE;
            running   <= 1'b0;
            presc_cnt <= 16'd0;
            step_cnt  <= 16'd0;
          end else begin
            presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
            if (boundary) begin
              pos_index     <= idx_next;
              HS            <= fault_pending ? FAULT_CODE : hall_code(idx_next);
              step_pulse    <= 1'b1;
              step_cnt      <= 16'd0;
              active_period <= shadow_next;
              last_dur      <= active_period;
              ele120_ref    <= dur_sat;
              first_done    <= 1'b1;
              if (first_done) begin
                ele120_valid <= 1'b1;
              end
              if (fault_pending) begin
                fault_pending <= 1'b0;
              end
            end else if (tick) begin
              step_cnt <= step_cnt + 16'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hall_pattern_gen.md
Name: hall_pattern_gen

Overview:
- Hall-sensor pattern transmitter: synthesises the 3-bit hall code HS[2:0] that the brushless commutation logic receives.
- Lets the drive path (hall decode, HSCounter, ele120_time, rotateState) be exercised on the bench without a motor.
- Sits beside the commutation core on controlCLK. Its HS output muxes onto the hall input path when emulation is selected.
- Also emits a reference 120-electrical-degree time for cross-checking the measured ele120_time.

Parameters:
- PRESC_DIV, 100: controlCLK cycles per step tick; legal range 1..65535.
- MIN_PERIOD, 4: minimum step period in ticks; smaller requested values are clamped to this.
- FAULT_CODE, 3'b000: illegal hall code driven during an injected fault step.

Ports:
- controlCLK  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = generate steps; 0 = freeze HS.
- dir  in  1  1 = forward, 0 = reverse; sampled at step boundaries.
- period_in  in  16  requested 60-electrical-degree step period, in ticks.
- period_wr  in  1  one-cycle strobe that writes period_in into the shadow register.
- fault_inject  in  1  one-cycle strobe; arms a single fault step.
- HS  out  3  emulated hall code.
- step_pulse  out  1  one-cycle pulse, coincident with each HS change.
- pos_index  out  3  current sequence index, 0..5.
- ele120_ref  out  16  saturating sum of the last two completed step durations, in ticks.
- ele120_valid  out  1  1 once two steps have completed since leaving IDLE.
- running  out  1  1 while in RUN.

Behaviour:
- Reset values: HS=3'b001, pos_index=0, step_pulse=0, ele120_ref=0, ele120_valid=0, running=0. Shadow period resets to MIN_PERIOD; fault_pending resets to 0.
- Reset is asynchronous and takes effect mid-step: the counter and prescaler clear immediately.
- Sequence table, indexed 0..5: 001, 011, 010, 110, 100, 101.
  - Forward: index+1, with 5 wrapping to 0.
  - Reverse: index-1, with 0 wrapping to 5.
- Shadow period:
  - period_wr loads max(period_in, MIN_PERIOD) into the shadow register; period_in=0 is therefore clamped.
  - The active period is loaded from the shadow register only on IDLE->RUN and at each step boundary.
  - period_wr in the same cycle as a boundary is write-through: the new value becomes active for the next step.
- Prescaler: counts 0..PRESC_DIV-1 while in RUN. tick=1 in the cycle the count equals PRESC_DIV-1. With PRESC_DIV=1, tick=1 on every cycle.
- FSM IDLE:
  - running=0; HS holds its value.
  - When enable=1, go to RUN. On entry, step counter=0, prescaler=0, active period=shadow, ele120_valid=0, and the history registers clear.
- FSM RUN:
  - Each tick increments the step counter.
  - Boundary = tick && counter==active-1. At a boundary, in the following registered cycle:
    - pos_index advances per dir;
    - HS updates;
    - step_pulse=1 for one cycle;
    - the counter clears;
    - active period reloads from shadow.
  - First HS change occurs exactly active*PRESC_DIV cycles after the cycle in which enable was sampled high.
  - enable=0 goes to IDLE on the next edge. HS and pos_index freeze, no step_pulse is issued, and any partial step is discarded.
- dir change mid-step: takes effect at the next boundary only.
- Fault:
  - fault_inject in RUN sets fault_pending; it is ignored in IDLE.
  - At the next boundary, pos_index advances normally but HS=FAULT_CODE for that step, and fault_pending clears.
  - The boundary after that outputs the table code for the current index.
  - A repeat strobe while fault is already pending is absorbed.
- ele120:
  - At each boundary, last_dur = completed step length in ticks (= active period).
  - ele120_ref = prev_dur + last_dur, computed as a 17-bit sum saturated to 16'hFFFF.
  - ele120_valid sets at the second boundary after RUN entry.
- Reset, enable and boundary in the same cycle: reset dominates. Otherwise enable=0 dominates a boundary: no step is taken.

Test Plan:
- Forward run: PRESC_DIV=1, period_wr with 4, dir=1, enable=1 at cycle 0.
  - HS steps 011,010,110,100,101,001 at cycles 4,8,...,24, with step_pulse at each.
  - ele120_ref=8 and ele120_valid=1 from cycle 8.
- Reverse run: same setup with dir=0. HS goes 101,100,110,010,011,001 and pos_index goes 5,4,3,2,1,0.
- Period change: write 10 mid-step while running at 4.
  - Current step still ends at 4.
  - Next step lasts 10, ele120_ref=14, then 20.
- Clamp and saturation:
  - period_in=0 gives steps of MIN_PERIOD=4.
  - period_in=16'hF000 gives ele120_ref=16'hFFFF after two steps.
- Fault: fault_inject mid-step at index 1.
  - Next boundary gives HS=000 with pos_index=2.
  - Following boundary gives HS=110.
- Stop/reset: enable drops at mid-step 2.
  - HS holds 011 with no pulse; re-enable restarts a full 4-cycle step.
  - rst_n low mid-run gives HS=001 and ele120_ref=0 asynchronously.
